regfile_ctrl: RTL and testbench
===============================

Name: regfile_ctrl

Overview:
- Controls the 16x16 register file (array of per-register bitcell registers, two tri-state read bitlines, one write data bus).
- Decodes read/write register numbers into one-hot enables and arbitrates the single write port between two sources: ALU writeback (wb) and load/multi-cycle return (ld).
- Keeps a pending-write scoreboard and flags read hazards.
- Forwards the write that commits this cycle onto the read data.

Parameters:
- NREG, 16, number of registers (one-hot enable width).
- DW, 16, data width.
- RW, 4, register-number width (log2 NREG).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rd_en1  in  1  read port 1 active
- rs1  in  RW  read port 1 register number
- rd_en2  in  1  read port 2 active
- rs2  in  RW  read port 2 register number
- ReadEnable1  out  NREG  one-hot read enable to register file, bitline 1
- ReadEnable2  out  NREG  one-hot read enable, bitline 2
- Bitline1  in  DW  value driven on bitline 1
- Bitline2  in  DW  value driven on bitline 2
- rdata1  out  DW  port 1 read data after bypass
- rdata2  out  DW  port 2 read data after bypass
- wb_valid  in  1  writeback request
- wb_reg  in  RW  writeback destination
- wb_data  in  DW  writeback data
- wb_ready  out  1  writeback accepted this cycle
- ld_valid  in  1  load-return request
- ld_reg  in  RW  load destination
- ld_data  in  DW  load data
- ld_ready  out  1  load accepted this cycle
- issue_valid  in  1  long-latency op issued; marks destination pending
- issue_reg  in  RW  pending destination
- WriteReg  out  NREG  one-hot write enable to register file
- D  out  DW  write data to register file
- hazard  out  1  a requested source is pending and not bypassed this cycle

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- State:
  - last_grant: 1 bit, 0=wb, 1=ld.
  - pending: NREG bits.
- Reset state: last_grant=1 (wb wins the first conflict); pending=0.
- While rst=1, all outputs are forced to 0: wb_ready, ld_ready, WriteReg, ReadEnable1/2, hazard, D, rdata1/2.
- Arbitration (combinational, registered pointer):
  - Only wb_valid: wb granted.
  - Only ld_valid: ld granted.
  - Both valid: the source not equal to last_grant wins.
  - last_grant updates to the winner on every grant; it holds when there is no grant.
  - ready is asserted only for the granted source, in the same cycle. The loser must hold valid/reg/data stable until its ready.
- Write:
  - granted source drives D = its data.
  - WriteReg = one-hot(reg).
  - Register commits at the next clk edge (latency 1).
  - Register 0 is constant zero. A grant to reg 0 is still accepted (ready=1), but WriteReg=0.
- Read:
  - ReadEnable1 = rd_en1 ? one-hot(rs1) : 0; likewise port 2.
  - rdata = Bitline, with bypass below.
  - If rd_en1=0, rdata1=0 and Bitline1 is ignored (bitlines float).
  - rs=0 returns 0 regardless of bitline.
- Bypass: if a grant this cycle targets a nonzero reg equal to rs1 (or rs2), rdata takes the granted data, not the bitline.
- Scoreboard:
  - issue_valid with issue_reg!=0 sets pending[issue_reg] at the clk edge.
  - ld grant with ld_reg clears pending[ld_reg].
  - Set and clear on the same reg in the same cycle: set wins (a new issue supersedes).
  - wb grant does not alter pending.
- hazard = (rd_en1 & pending[rs1] & !bypass1) | (rd_en2 & pending[rs2] & !bypass2). It is purely combinational from the current state and inputs.
- Reset mid-operation clears pending and the pointer at that edge. No write commits in a cycle where rst=1.

Decomposition:
- Package regfile_pkg holds:
  - constants NREG, DW, RW
  - REG_ZERO = 0
  - grant-source enum {SRC_WB, SRC_LD}
- One sub-module: rr_arb2, a 2-requester round-robin arbiter holding last_grant, with inputs req[1:0] and outputs gnt[1:0].
- Decoders and bypass muxes are inline.

Test Plan:
- Reset, then wb_valid, wb_reg=3, wb_data=0x1234 -> wb_ready=1, WriteReg=0x0008, D=0x1234 the same cycle; next cycle rs1=3 reads 0x1234.
- Conflict over 3 consecutive cycles, wb_reg=5 / ld_reg=6 both held valid -> grants in the order wb, ld, wb. Loser ready=0 until its turn.
- issue_valid with issue_reg=7, then rs2=7 with rd_en2 -> hazard=1. ld_reg=7, ld_data=0xBEEF granted -> hazard=0 and rdata2=0xBEEF (bypass) that cycle; pending[7]=0 after.
- ld_reg=0, ld_data=0xFFFF -> ld_ready=1, WriteReg=0; rs1=0 returns rdata1=0; issue_reg=0 does not set hazard.
- Same cycle: issue_reg=4 and ld grant to reg 4 -> pending[4]=1 afterwards, and hazard=1 on the following read of r4.
- Assert rst with pending=0x00F0 and both requests valid -> all outputs 0 during rst; afterwards pending=0 and the first conflict is granted to wb.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, grant-source encoding and the register-number decoder
// used by the register-file controller.
package regfile_pkg;

  localparam int NREG = 16;
  localparam int DW   = 16;
  localparam int RW   = 4;

  localparam logic [RW-1:0] REG_ZERO = 4'd0;

  typedef enum logic {
    SRC_WB = 1'b0,
    SRC_LD = 1'b1
  } src_e;

  function automatic logic [NREG-1:0] onehot(input logic [RW-1:0] idx);
    return {{(NREG-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: req[0]/gnt[0] is writeback, req[1]/gnt[1]
// is load return; on a conflict the source that did not win last time wins.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  src_e r_last_grant;

  // Grant selection from the request pair and the last winner
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (r_last_grant == SRC_LD) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer follows every grant; reset favours writeback on the first conflict
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= SRC_LD;
    end else if (gnt[0]) begin
      r_last_grant <= SRC_WB;
    end else if (gnt[1]) begin
      r_last_grant <= SRC_LD;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file controller: read/write decode, write-port arbitration between
// writeback and load return, pending-write scoreboard and same-cycle bypass.
module regfile_ctrl
  import regfile_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rd_en1,
  input  logic [RW-1:0]   rs1,
  input  logic            rd_en2,
  input  logic [RW-1:0]   rs2,
  output logic [NREG-1:0] ReadEnable1,
  output logic [NREG-1:0] ReadEnable2,
  input  logic [DW-1:0]   Bitline1,
  input  logic [DW-1:0]   Bitline2,
  output logic [DW-1:0]   rdata1,
  output logic [DW-1:0]   rdata2,
  input  logic            wb_valid,
  input  logic [RW-1:0]   wb_reg,
  input  logic [DW-1:0]   wb_data,
  output logic            wb_ready,
  input  logic            ld_valid,
  input  logic [RW-1:0]   ld_reg,
  input  logic [DW-1:0]   ld_data,
  output logic            ld_ready,
  input  logic            issue_valid,
  input  logic [RW-1:0]   issue_reg,
  output logic [NREG-1:0] WriteReg,
  output logic [DW-1:0]   D,
  output logic            hazard
);

  logic [1:0]      w_gnt;
  logic            w_any_gnt;
  logic [RW-1:0]   w_g_reg;
  logic [DW-1:0]   w_g_data;
  logic            w_bypass1;
  logic            w_bypass2;
  logic            w_hazard;
  logic [NREG-1:0] w_pending_nxt;
  logic [NREG-1:0] r_pending;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({ld_valid, wb_valid}),
    .gnt (w_gnt)
  );

  // Select the granted source's destination and data
  always_comb begin
    w_any_gnt = w_gnt[0] | w_gnt[1];
    if (w_gnt[0]) begin
      w_g_reg  = wb_reg;
      w_g_data = wb_data;
    end else if (w_gnt[1]) begin
      w_g_reg  = ld_reg;
      w_g_data = ld_data;
    end else begin
      w_g_reg  = REG_ZERO;
      w_g_data = {DW{1'b0}};
    end
  end

  // Bypass and hazard detection; register 0 is never pending nor forwarded
  always_comb begin
    w_bypass1 = w_any_gnt && (w_g_reg != REG_ZERO) && (w_g_reg == rs1);
    w_bypass2 = w_any_gnt && (w_g_reg != REG_ZERO) && (w_g_reg == rs2);
    w_hazard  = (rd_en1 & r_pending[rs1] & ~w_bypass1) |
                (rd_en2 & r_pending[rs2] & ~w_bypass2);
  end

  // Scoreboard next state: a new issue overrides a same-cycle load clear
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_gnt[1]) begin
      w_pending_nxt[ld_reg] = 1'b0;
    end else begin
      w_pending_nxt = w_pending_nxt;
    end
    if (issue_valid && (issue_reg != REG_ZERO)) begin
      w_pending_nxt[issue_reg] = 1'b1;
    end else begin
      w_pending_nxt = w_pending_nxt;
    end
  end

  // Pending-write scoreboard register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= {NREG{1'b0}};
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  // Output drive; everything is held at zero while reset is asserted
  always_comb begin
    wb_ready    = 1'b0;
    ld_ready    = 1'b0;
    WriteReg    = {NREG{1'b0}};
    D           = {DW{1'b0}};
    ReadEnable1 = {NREG{1'b0}};
    ReadEnable2 = {NREG{1'b0}};
    rdata1      = {DW{1'b0}};
    rdata2      = {DW{1'b0}};
    hazard      = 1'b0;
    if (!rst) begin
      wb_ready = w_gnt[0];
      ld_ready = w_gnt[1];
      D        = w_g_data;
      if (w_any_gnt && (w_g_reg != REG_ZERO)) begin
        WriteReg = onehot(w_g_reg);
      end else begin
        WriteReg = {NREG{1'b0}};
      end
      if (rd_en1) begin
        ReadEnable1 = onehot(rs1);
        if (rs1 == REG_ZERO) begin
          rdata1 = {DW{1'b0}};
        end else if (w_bypass1) begin
          rdata1 = w_g_data;
        end else begin
          rdata1 = Bitline1;
        end
      end else begin
        ReadEnable1 = {NREG{1'b0}};
        rdata1      = {DW{1'b0}};
      end
      if (rd_en2) begin
        ReadEnable2 = onehot(rs2);
        if (rs2 == REG_ZERO) begin
          rdata2 = {DW{1'b0}};
        end else if (w_bypass2) begin
          rdata2 = w_g_data;
        end else begin
          rdata2 = Bitline2;
        end
      end else begin
        ReadEnable2 = {NREG{1'b0}};
        rdata2      = {DW{1'b0}};
      end
      hazard = w_hazard;
    end else begin
      hazard = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed testbench for regfile_ctrl; bitline values stand in for the
// register-file array contents the bench expects at each step.
module tb_regfile_ctrl;

  logic        clk;
  logic        rst;
  logic        rd_en1, rd_en2;
  logic [3:0]  rs1, rs2;
  logic [15:0] ReadEnable1, ReadEnable2;
  logic [15:0] Bitline1, Bitline2;
  logic [15:0] rdata1, rdata2;
  logic        wb_valid, ld_valid, issue_valid;
  logic [3:0]  wb_reg, ld_reg, issue_reg;
  logic [15:0] wb_data, ld_data;
  logic        wb_ready, ld_ready;
  logic [15:0] WriteReg, D;
  logic        hazard;

  int checks = 0;
  int errors = 0;

  regfile_ctrl dut (
    .clk(clk), .rst(rst),
    .rd_en1(rd_en1), .rs1(rs1), .rd_en2(rd_en2), .rs2(rs2),
    .ReadEnable1(ReadEnable1), .ReadEnable2(ReadEnable2),
    .Bitline1(Bitline1), .Bitline2(Bitline2),
    .rdata1(rdata1), .rdata2(rdata2),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready),
    .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data), .ld_ready(ld_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .WriteReg(WriteReg), .D(D), .hazard(hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rd_en1 = 1'b0; rs1 = 4'd0; rd_en2 = 1'b0; rs2 = 4'd0;
    Bitline1 = 16'h0; Bitline2 = 16'h0;
    wb_valid = 1'b0; wb_reg = 4'd0; wb_data = 16'h0;
    ld_valid = 1'b0; ld_reg = 4'd0; ld_data = 16'h0;
    issue_valid = 1'b0; issue_reg = 4'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_ready"}, 32'(wb_ready), 32'd0);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
    chk({tag, "_WriteReg"}, 32'(WriteReg), 32'd0);
    chk({tag, "_D"}, 32'(D), 32'd0);
    chk({tag, "_RE1"}, 32'(ReadEnable1), 32'd0);
    chk({tag, "_RE2"}, 32'(ReadEnable2), 32'd0);
    chk({tag, "_rdata1"}, 32'(rdata1), 32'd0);
    chk({tag, "_rdata2"}, 32'(rdata2), 32'd0);
    chk({tag, "_hazard"}, 32'(hazard), 32'd0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    wb_valid = 1'b1; wb_reg = 4'd3; wb_data = 16'h1111;
    rd_en1 = 1'b1; rs1 = 4'd3; Bitline1 = 16'h2222;
    #1;
    chk_all_zero("reset_init");
    next_cycle();
    next_cycle();

    // Single writeback to r3
    rst = 1'b0; idle();
    wb_valid = 1'b1; wb_reg = 4'd3; wb_data = 16'h1234;
    #1;
    chk("wb3_ready", 32'(wb_ready), 32'd1);
    chk("wb3_ld_ready", 32'(ld_ready), 32'd0);
    chk("wb3_WriteReg", 32'(WriteReg), 32'h0008);
    chk("wb3_D", 32'(D), 32'h1234);
    next_cycle();

    // Read r3 from the array
    idle();
    rd_en1 = 1'b1; rs1 = 4'd3; Bitline1 = 16'h1234;
    #1;
    chk("rd3_RE1", 32'(ReadEnable1), 32'h0008);
    chk("rd3_rdata1", 32'(rdata1), 32'h1234);
    chk("rd3_hazard", 32'(hazard), 32'd0);
    next_cycle();

    // Disabled read port ignores its bitline
    idle();
    rd_en1 = 1'b0; rs1 = 4'd3; Bitline1 = 16'hDEAD;
    #1;
    chk("rdoff_rdata1", 32'(rdata1), 32'd0);
    chk("rdoff_RE1", 32'(ReadEnable1), 32'd0);
    next_cycle();

    // Issue long op to r7
    idle();
    issue_valid = 1'b1; issue_reg = 4'd7;
    #1;
    next_cycle();

    idle();
    rd_en2 = 1'b1; rs2 = 4'd7; Bitline2 = 16'h0BAD;
    #1;
    chk("haz7_hazard", 32'(hazard), 32'd1);
    chk("haz7_RE2", 32'(ReadEnable2), 32'h0080);
    next_cycle();

    // Load return to r7 is forwarded and clears the hazard
    idle();
    rd_en2 = 1'b1; rs2 = 4'd7; Bitline2 = 16'h0BAD;
    ld_valid = 1'b1; ld_reg = 4'd7; ld_data = 16'hBEEF;
    #1;
    chk("ld7_ready", 32'(ld_ready), 32'd1);
    chk("ld7_WriteReg", 32'(WriteReg), 32'h0080);
    chk("ld7_hazard", 32'(hazard), 32'd0);
    chk("ld7_bypass", 32'(rdata2), 32'hBEEF);
    next_cycle();

    idle();
    rd_en2 = 1'b1; rs2 = 4'd7; Bitline2 = 16'hBEEF;
    #1;
    chk("post7_hazard", 32'(hazard), 32'd0);
    chk("post7_rdata2", 32'(rdata2), 32'hBEEF);
    next_cycle();

    // Conflict after a load win: wb, ld, wb
    idle();
    wb_valid = 1'b1; wb_reg = 4'd5; wb_data = 16'h5A5A;
    ld_valid = 1'b1; ld_reg = 4'd6; ld_data = 16'h6B6B;
    #1;
    chk("cf1_wb_ready", 32'(wb_ready), 32'd1);
    chk("cf1_ld_ready", 32'(ld_ready), 32'd0);
    chk("cf1_WriteReg", 32'(WriteReg), 32'h0020);
    chk("cf1_D", 32'(D), 32'h5A5A);
    next_cycle();
    #1;
    chk("cf2_wb_ready", 32'(wb_ready), 32'd0);
    chk("cf2_ld_ready", 32'(ld_ready), 32'd1);
    chk("cf2_WriteReg", 32'(WriteReg), 32'h0040);
    chk("cf2_D", 32'(D), 32'h6B6B);
    next_cycle();
    #1;
    chk("cf3_wb_ready", 32'(wb_ready), 32'd1);
    chk("cf3_ld_ready", 32'(ld_ready), 32'd0);
    chk("cf3_WriteReg", 32'(WriteReg), 32'h0020);
    next_cycle();

    // Load to r0 is accepted but never written; issue to r0 is ignored
    idle();
    ld_valid = 1'b1; ld_reg = 4'd0; ld_data = 16'hFFFF;
    rd_en1 = 1'b1; rs1 = 4'd0; Bitline1 = 16'hAAAA;
    issue_valid = 1'b1; issue_reg = 4'd0;
    #1;
    chk("ld0_ready", 32'(ld_ready), 32'd1);
    chk("ld0_WriteReg", 32'(WriteReg), 32'd0);
    chk("ld0_rdata1", 32'(rdata1), 32'd0);
    next_cycle();

    idle();
    rd_en2 = 1'b1; rs2 = 4'd0; Bitline2 = 16'hAAAA;
    #1;
    chk("iss0_hazard", 32'(hazard), 32'd0);
    chk("iss0_rdata2", 32'(rdata2), 32'd0);
    next_cycle();

    // Same-cycle issue and load return on r4: set wins
    idle();
    issue_valid = 1'b1; issue_reg = 4'd4;
    ld_valid = 1'b1; ld_reg = 4'd4; ld_data = 16'h4444;
    #1;
    chk("sc4_ld_ready", 32'(ld_ready), 32'd1);
    chk("sc4_WriteReg", 32'(WriteReg), 32'h0010);
    next_cycle();

    idle();
    rd_en1 = 1'b1; rs1 = 4'd4; Bitline1 = 16'h4444;
    issue_valid = 1'b1; issue_reg = 4'd5;
    wb_valid = 1'b1; wb_reg = 4'd8; wb_data = 16'h8888;
    #1;
    chk("sc4_hazard", 32'(hazard), 32'd1);
    chk("wb8_ready", 32'(wb_ready), 32'd1);
    next_cycle();

    idle();
    issue_valid = 1'b1; issue_reg = 4'd6;
    #1;
    next_cycle();

    idle();
    issue_valid = 1'b1; issue_reg = 4'd7;
    rd_en2 = 1'b1; rs2 = 4'd6; Bitline2 = 16'h6B6B;
    #1;
    chk("pend6_hazard", 32'(hazard), 32'd1);
    next_cycle();

    // Reset mid-operation with pending = 0x00F0 and both sources requesting
    idle();
    rst = 1'b1;
    wb_valid = 1'b1; wb_reg = 4'd9;  wb_data = 16'h9999;
    ld_valid = 1'b1; ld_reg = 4'd10; ld_data = 16'hAAAA;
    rd_en1 = 1'b1; rs1 = 4'd5; Bitline1 = 16'h1357;
    rd_en2 = 1'b1; rs2 = 4'd6; Bitline2 = 16'h2468;
    #1;
    chk_all_zero("midrst");
    next_cycle();

    rst = 1'b0;
    #1;
    chk("prst_wb_ready", 32'(wb_ready), 32'd1);
    chk("prst_ld_ready", 32'(ld_ready), 32'd0);
    chk("prst_WriteReg", 32'(WriteReg), 32'h0200);
    chk("prst_hazard", 32'(hazard), 32'd0);
    chk("prst_rdata1", 32'(rdata1), 32'h1357);
    next_cycle();

    idle();
    rd_en1 = 1'b1; rs1 = 4'd4; Bitline1 = 16'h4444;
    rd_en2 = 1'b1; rs2 = 4'd7; Bitline2 = 16'hBEEF;
    #1;
    chk("prst_hazard47", 32'(hazard), 32'd0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
